// File: rtl/ram_port_ctrl_pkg.sv
// Shared definitions for the block-RAM port controller.
//   state_t        : controller FSM encoding
//   RD_FIFO_DEPTH  : read-return buffer depth (issue throttle is sized to it)
package ram_port_ctrl_pkg;

  localparam int RD_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_port_ctrl_if.sv
// Bundle of the controller's command, write-stream, read-stream and RAM pins.
//   master : host/protocol-engine + RAM side (drives in_*, observes out_*)
//   slave  : the controller itself (drives out_*, observes in_*)
interface ram_port_ctrl_if #(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int LEN_WIDTH      = RAM_ADDR_WIDTH + 1
);
  // command
  logic                      in_cmd_valid;
  logic                      out_cmd_ready;
  logic                      in_cmd_rd;
  logic [RAM_ADDR_WIDTH-1:0] in_cmd_addr;
  logic [LEN_WIDTH-1:0]      in_cmd_len;
  // write stream
  logic [RAM_DATA_WIDTH-1:0] in_wdata;
  logic                      in_wdata_valid;
  logic                      out_wdata_ready;
  // read stream
  logic [RAM_DATA_WIDTH-1:0] out_rdata;
  logic                      out_rdata_valid;
  logic                      in_rdata_ready;
  // RAM
  logic [RAM_ADDR_WIDTH-1:0] out_ram_addr;
  logic                      out_ram_wr;
  logic [RAM_DATA_WIDTH-1:0] out_ram_data;
  logic [RAM_DATA_WIDTH-1:0] in_ram_data;
  // status
  logic                      out_busy;
  logic                      out_done;

  modport master (
    output in_cmd_valid, in_cmd_rd, in_cmd_addr, in_cmd_len,
    output in_wdata, in_wdata_valid, in_rdata_ready, in_ram_data,
    input  out_cmd_ready, out_wdata_ready, out_rdata, out_rdata_valid,
    input  out_ram_addr, out_ram_wr, out_ram_data, out_busy, out_done
  );

  modport slave (
    input  in_cmd_valid, in_cmd_rd, in_cmd_addr, in_cmd_len,
    input  in_wdata, in_wdata_valid, in_rdata_ready, in_ram_data,
    output out_cmd_ready, out_wdata_ready, out_rdata, out_rdata_valid,
    output out_ram_addr, out_ram_wr, out_ram_data, out_busy, out_done
  );

endinterface

// File: rtl/ram_port_ctrl_rd_skid_fifo.sv
// rd_skid_fifo: 2-entry buffer for words returning from the RAM.
//   in_clk/in_rst_n : clock, synchronous active-low reset
//   in_push/in_data : write one word
//   in_pop          : consume head (ignored when empty)
//   out_head/out_valid : head word and its valid
//   out_occ         : occupancy 0..2
// Push and pop in the same cycle keep occupancy and order. Overflow is
// prevented by the issuer, which never lets occupancy + in-flight exceed 2.
module rd_skid_fifo #(
  parameter int W = 8
) (
  input  logic         in_clk,
  input  logic         in_rst_n,
  input  logic         in_push,
  input  logic [W-1:0] in_data,
  input  logic         in_pop,
  output logic [W-1:0] out_head,
  output logic         out_valid,
  output logic [1:0]   out_occ
);

  logic [1:0][W-1:0] mem;
  logic              rd_ptr, wr_ptr;
  logic              do_pop;

  assign do_pop    = in_pop & out_valid;
  assign out_valid = (out_occ != 2'd0);
  assign out_head  = mem[rd_ptr];

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      mem     <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      out_occ <= 2'd0;
    end else begin
      if (in_push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({in_push, do_pop})
        2'b10:   out_occ <= out_occ + 2'd1;
        2'b01:   out_occ <= out_occ - 2'd1;
        default: out_occ <= out_occ;
      endcase
    end
  end

endmodule

// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: burst initiator for a single-port block RAM with a
// 1-cycle registered read.
//   in_clk, in_rst_n : clock, synchronous active-low reset
//   bus (slave)      : command (valid/ready, rd, addr, len), write stream,
//                      read stream, RAM addr/wr/data pins, busy/done status
// Reads are issued only while the return buffer has room for the word in
// flight plus anything already buffered, so a 2-entry buffer is enough to
// stream 1 word/cycle under arbitrary backpressure.
module ram_port_ctrl
  import ram_port_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int LEN_WIDTH      = RAM_ADDR_WIDTH + 1
) (
  input logic            in_clk,
  input logic            in_rst_n,
  ram_port_ctrl_if.slave bus
);

  localparam int AW = RAM_ADDR_WIDTH;
  localparam int LW = LEN_WIDTH;

  state_t                    state;
  logic [AW-1:0]             cur_addr;
  logic [LW-1:0]             remaining;  // words left to accept (write) / issue (read)
  logic                      inflight;   // read issued last cycle, data on in_ram_data now
  logic                      cmd_ready_q, busy_q, done_q, wdata_ready_q;

  logic [1:0]                occ;
  logic                      fifo_vld;
  logic [RAM_DATA_WIDTH-1:0] fifo_head;
  logic                      pop, issue, wr_acc;

  assign pop    = fifo_vld & bus.in_rdata_ready;
  assign wr_acc = bus.in_wdata_valid & wdata_ready_q;
  // room check: buffered + in flight - leaving this cycle must stay below depth
  assign issue  = (state == ST_READ) && (remaining != '0) &&
                  (({1'b0, occ} + {2'b0, inflight}) < (3'(RD_FIFO_DEPTH) + {2'b0, pop}));

  rd_skid_fifo #(.W(RAM_DATA_WIDTH)) u_fifo (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .in_push  (inflight),
    .in_data  (bus.in_ram_data),
    .in_pop   (pop),
    .out_head (fifo_head),
    .out_valid(fifo_vld),
    .out_occ  (occ)
  );

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state         <= ST_IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wdata_ready_q <= 1'b0;
    end else begin
      inflight <= issue;
      done_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.in_cmd_valid) begin
            cur_addr    <= bus.in_cmd_addr;
            remaining   <= bus.in_cmd_len;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.in_cmd_len == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else if (bus.in_cmd_rd) begin
              state <= ST_READ;
            end else begin
              state         <= ST_WRITE;
              wdata_ready_q <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (wr_acc) begin
            cur_addr  <= cur_addr + AW'(1);
            remaining <= remaining - LW'(1);
            if (remaining == LW'(1)) begin
              state         <= ST_DONE;
              done_q        <= 1'b1;
              wdata_ready_q <= 1'b0;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            cur_addr  <= cur_addr + AW'(1);
            remaining <= remaining - LW'(1);
          end else if (remaining == '0 && !inflight && occ == 2'd0) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_cmd_ready   = cmd_ready_q;
  assign bus.out_busy        = busy_q;
  assign bus.out_done        = done_q;
  assign bus.out_wdata_ready = wdata_ready_q;
  assign bus.out_ram_addr    = cur_addr;
  assign bus.out_ram_wr      = wr_acc;
  // write data only leaves the block while a write burst is accepting
  assign bus.out_ram_data    = wdata_ready_q ? bus.in_wdata : '0;
  assign bus.out_rdata_valid = fifo_vld;
  assign bus.out_rdata       = fifo_vld ? fifo_head : '0;

endmodule
